fetch_if_id_stage: RTL
======================

Name: fetch_if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the main decode controller.
- Owns the PC and issues one request at a time to instruction memory, which has variable latency.
- Captures the returned instruction with its PC in the IF/ID register.
- Presents the opcode field to the decode controller and honours stall (hazard unit) and redirect (taken branch from EX).

Parameters:
- PC_W, 9, PC/byte-address width; PC wraps modulo 2^PC_W.
- INS_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset (bits [1:0] must be 0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the IF/ID register and do not accept a new instruction into it.
- redirect  in  1  taken branch: flush IF/ID and load the PC from redirect_pc.
- redirect_pc  in  PC_W  branch target; bits [1:0] are ignored and treated as 0.
- imem_req  out  1  request strobe, high exactly one cycle per request.
- imem_addr  out  PC_W  request address, equal to the current PC; stable until the response.
- imem_rvalid  in  1  response valid; earliest the cycle after imem_req.
- imem_rdata  in  INS_W  instruction data, qualified by imem_rvalid.
- ifid_valid  out  1  IF/ID register holds a real instruction.
- ifid_pc  out  PC_W  PC of the instruction in IF/ID.
- ifid_instr  out  INS_W  instruction in IF/ID.
- ifid_opcode  out  7  ifid_instr[6:0]; feeds the decode controller.

Behaviour:
- Clock and reset: single clock domain. reset is synchronous and active-high, sampled on the clk rising edge, with priority over everything else.
- Reset values:
  - state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - ifid_valid=0, ifid_pc=0, ifid_instr=32'h00000013 (NOP, addi x0,x0,0), ifid_opcode=7'b0010011.
  - Skid buffer cleared.
- Priority each cycle: reset > redirect > stall > normal.
- Outputs: imem_req = (state==ISSUE), decoded from state only; imem_addr = pc register.
- FSM states: BOOT, ISSUE, WAIT, DROP, HOLD.
  - BOOT -> ISSUE unconditionally. This gives one idle cycle after reset.
  - ISSUE: request is sent; always -> WAIT.
    - If redirect: pc<=redirect_pc and -> DROP, because the request is already in flight.
  - WAIT, redirect: pc<=redirect_pc. If imem_rvalid in the same cycle, discard the data and -> ISSUE; otherwise -> DROP.
  - WAIT, imem_rvalid, no redirect, !stall: IF/ID <= {1, pc, imem_rdata}; pc<=pc+4; -> ISSUE.
  - WAIT, imem_rvalid, no redirect, stall: skid <= {pc, imem_rdata}; pc<=pc+4; -> HOLD.
  - WAIT, no imem_rvalid: stay in WAIT.
  - DROP: imem_rvalid discards the data and -> ISSUE. A further redirect in DROP only updates pc.
  - HOLD, redirect: discard skid; pc<=redirect_pc; -> ISSUE.
  - HOLD, !stall: IF/ID <= {1, skid}; -> ISSUE.
  - HOLD, stall: stay in HOLD.
- IF/ID register update rules:
  - redirect: ifid_valid<=0, ifid_instr<=NOP, ifid_pc unchanged. Flush wins over stall.
  - stall without redirect: all IF/ID fields hold.
  - !stall and no instruction delivered this cycle: bubble, ifid_valid<=0, ifid_instr<=NOP.
- Exactly one request is outstanding at a time. A new imem_req is never issued while in WAIT or DROP.
- Latency:
  - imem_req in cycle n; 1-cycle memory gives rvalid in n+1.
  - ifid_* show the instruction in n+2; the next imem_req is in n+2.
  - Throughput is one instruction per 2 cycles with 1-cycle memory.
- PC arithmetic: pc+4 truncated to PC_W bits, so (2^PC_W-4)+4 wraps to 0.
- imem_rvalid is ignored in BOOT, ISSUE and HOLD. It is a protocol violation in those states and must not change state.

Test Plan:
- Reset, 1-cycle memory with rdata=addr-tagged values:
  - imem_req pulses at cycles 1, 3, 5 with addr 0, 4, 8.
  - ifid_pc shows 0 / 4 / 8 with ifid_valid=1 at cycles 3, 5, 7.
  - ifid_opcode equals rdata[6:0].
- stall high in the rvalid cycle at pc=4, held 3 cycles:
  - state HOLD; IF/ID holds pc=0.
  - After release, ifid_pc=4 with the buffered data.
  - Next imem_addr=8.
- 3-cycle memory, redirect to 0x40 one cycle after imem_req:
  - state DROP; the stale response is not loaded (ifid_valid=0).
  - Next imem_addr=0x40; its instruction reaches IF/ID.
- redirect to 0x80 in the same cycle as imem_rvalid in WAIT:
  - data discarded; ifid_valid=0.
  - Next cycle imem_req=1 with addr 0x80.
- In HOLD with stall=1 and redirect=1 to 0x20:
  - IF/ID flushed (valid=0, instr=NOP); skid discarded.
  - Next imem_addr=0x20.
- PC_W=9, redirect to 508:
  - after fetch, next imem_addr=0 (wrap).
  - reset asserted mid-WAIT returns all outputs to reset values next cycle, and the late rvalid is ignored.

Source files
------------

// File: rtl/fetch_if_id_stage.sv
// fetch_if_id_stage
// Instruction-fetch stage plus IF/ID pipeline register feeding the decode
// controller. The stage owns the PC and keeps at most one request in flight
// to a variable-latency instruction memory.
//
// The fetched instruction lands in IF/ID together with its PC. If decode is
// stalled when the response arrives, the instruction is parked in a one-entry
// skid buffer.
//
// A taken branch from EX (redirect) flushes IF/ID and reloads the PC. If a
// request is still in flight when the redirect arrives, its response is
// dropped.
//
// Memory handshake: imem_req is a one-cycle strobe asserted while the FSM is in
// ISSUE, and imem_addr carries the PC register. The memory answers with exactly
// one imem_rvalid pulse, at the earliest in the cycle after imem_req.
// imem_rdata is meaningful only while imem_rvalid is high. No further request
// is issued until that pulse has been seen. A pulse arriving in BOOT, ISSUE or
// HOLD is a protocol violation and is ignored.
//
// dbg_state exposes the FSM state with the encoding
// BOOT=0, ISSUE=1, WAIT=2, DROP=3, HOLD=4.

module fetch_if_id_stage #(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_rvalid,
    input  logic [INS_W-1:0] imem_rdata,
    output logic             ifid_valid,
    output logic [PC_W-1:0]  ifid_pc,
    output logic [INS_W-1:0] ifid_instr,
    output logic [6:0]       ifid_opcode,
    output logic [2:0]       dbg_state
);

    // FSM encoding (kept stable: dbg_state reports these values)
    localparam logic [2:0] S_BOOT  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DROP  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    // addi x0,x0,0 -- what IF/ID shows whenever it holds no real instruction
    localparam logic [INS_W-1:0] NOP_INSTR = INS_W'(32'h0000_0013);
    localparam logic [PC_W-1:0]  PC_STEP   = PC_W'(4);
    localparam logic [PC_W-1:0]  PC_ALIGN  = ~PC_W'(3);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [2:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;

    logic             ifid_valid_q, ifid_valid_d;
    logic [PC_W-1:0]  ifid_pc_q, ifid_pc_d;
    logic [INS_W-1:0] ifid_instr_q, ifid_instr_d;

    logic [PC_W-1:0]  skid_pc_q, skid_pc_d;
    logic [INS_W-1:0] skid_instr_q, skid_instr_d;

    // ------------------------------------------------------------------
    // Helper signals
    // ------------------------------------------------------------------
    logic [PC_W-1:0]  target_pc;    // redirect target with bits [1:0] forced to 0
    logic [PC_W-1:0]  pc_next_seq;  // pc + 4, wraps modulo 2^PC_W
    logic             deliver;      // an instruction enters IF/ID this cycle
    logic [PC_W-1:0]  deliver_pc;
    logic [INS_W-1:0] deliver_instr;

    assign target_pc   = redirect_pc & PC_ALIGN;
    assign pc_next_seq = pc_q + PC_STEP;

    // FSM: next state, PC, skid buffer, and what (if anything) reaches IF/ID
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        skid_pc_d     = skid_pc_q;
        skid_instr_d  = skid_instr_q;
        deliver       = 1'b0;
        deliver_pc    = pc_q;
        deliver_instr = imem_rdata;

        case (state_q)
            S_BOOT: begin
                // One idle cycle after reset; a branch here still retargets the PC
                state_d = S_ISSUE;
                if (redirect) begin
                    pc_d = target_pc;
                end
            end

            S_ISSUE: begin
                // The request leaves this cycle whatever else happens
                if (redirect) begin
                    pc_d    = target_pc;
                    state_d = S_DROP;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect) begin
                    // Response (if any) belongs to the wrong path
                    pc_d    = target_pc;
                    state_d = imem_rvalid ? S_ISSUE : S_DROP;
                end else if (imem_rvalid) begin
                    pc_d = pc_next_seq;
                    if (stall) begin
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_rdata;
                        state_d      = S_HOLD;
                    end else begin
                        deliver       = 1'b1;
                        deliver_pc    = pc_q;
                        deliver_instr = imem_rdata;
                        state_d       = S_ISSUE;
                    end
                end
            end

            S_DROP: begin
                // Waiting out a stale response; later redirects only move the PC
                if (redirect) begin
                    pc_d = target_pc;
                end
                if (imem_rvalid) begin
                    state_d = S_ISSUE;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    skid_pc_d    = '0;
                    skid_instr_d = NOP_INSTR;
                    pc_d         = target_pc;
                    state_d      = S_ISSUE;
                end else if (!stall) begin
                    deliver       = 1'b1;
                    deliver_pc    = skid_pc_q;
                    deliver_instr = skid_instr_q;
                    state_d       = S_ISSUE;
                end
            end

            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // IF/ID register: flush beats stall, stall holds, otherwise load or bubble
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;

        if (redirect) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (stall) begin
            ifid_valid_d = ifid_valid_q;
        end else if (deliver) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = deliver_pc;
            ifid_instr_d = deliver_instr;
        end else begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end
    end

    // Register update with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    // Outputs come straight from registers
    assign imem_req    = (state_q == S_ISSUE);
    assign imem_addr   = pc_q;
    assign ifid_valid  = ifid_valid_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_opcode = ifid_instr_q[6:0];
    assign dbg_state   = state_q;

endmodule
